if_stage: RTL
=============

# if_stage

Instruction fetch stage with integrated IF/ID output register. Holds the program counter, issues one-at-a-time fetches over a request/grant/response handshake to instruction memory, and presents the fetched instruction plus its PC to the decode stage, which feeds the ID/EXE pipeline register. Supports decode-side stall and EXE-side branch redirect/flush, with a one-entry skid buffer so no fetched instruction is lost under stall.

## Interface
- ADDR_W, 32, PC / instruction address width
- INST_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven when no valid instruction
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset; asynchronous and active-high
- stall_i  in  1  decode cannot accept; hold inst_o/pc_o/inst_valid_o
- flush_i  in  1  branch taken / redirect from EXE; highest priority
- redirect_pc_i  in  ADDR_W  new fetch address, sampled when flush_i=1; bits [1:0] forced to 0
- imem_req_o  out  1  fetch request
- imem_addr_o  out  ADDR_W  fetch address, valid while imem_req_o=1
- imem_gnt_i  in  1  memory accepts request this cycle
- imem_rvalid_i  in  1  response valid; earliest 1 cycle after grant, in order
- imem_rdata_i  in  INST_W  fetched instruction
- inst_o  out  INST_W  instruction to decode
- pc_o  out  ADDR_W  address of inst_o
- inst_valid_o  out  1  inst_o/pc_o hold a real instruction

## Operation
- Internal state: pc_q (next fetch address), req_pc_q (address of in-flight fetch), kill_q, skid buffer (inst+pc+full flag), FSM {IDLE, REQ, WAIT, HOLD}.
- IDLE: entered only via reset; next cycle -> REQ.
- REQ: imem_req_o=1, imem_addr_o=pc_q. On imem_gnt_i: req_pc_q<=pc_q, pc_q<=pc_q+4 (wraps modulo 2^ADDR_W), -> WAIT.
- WAIT: imem_req_o=0; at most one fetch outstanding. On imem_rvalid_i:
  - kill_q=1: discard data, clear kill_q, -> REQ.
  - output slot free (inst_valid_o=0 or stall_i=0): inst_o<=imem_rdata_i, pc_o<=req_pc_q, inst_valid_o<=1, -> REQ.
  - else (inst_valid_o=1 and stall_i=1): write skid buffer, -> HOLD.
- HOLD: imem_req_o=0. When stall_i=0: skid -> inst_o/pc_o, inst_valid_o stays 1, skid cleared, -> REQ.
- Consumption: inst_valid_o=1 and stall_i=0 with no new instruction loaded that cycle -> inst_valid_o<=0, inst_o<=NOP_INST.
- Flush (any state except IDLE): pc_q<=redirect_pc_i&~3; inst_valid_o<=0; inst_o<=NOP_INST; skid cleared. From WAIT without rvalid in same cycle -> stay WAIT with kill_q<=1. From REQ with imem_gnt_i in same cycle -> WAIT with kill_q<=1 (granted fetch is wrong-path). From WAIT with rvalid same cycle, from REQ without grant, or from HOLD -> REQ. Flush overrides stall and any same-cycle load.
- Flush during kill_q=1 WAIT: kill_q stays 1, pc_q updated to newest redirect_pc_i.

## Timing
- Reset (async assert): pc_q=RESET_PC, req_pc_q=0, kill_q=0, skid empty, state IDLE, imem_req_o=0, imem_addr_o=RESET_PC, inst_o=NOP_INST, pc_o=0, inst_valid_o=0.
- After reset release edge E0: E1 -> REQ (imem_req_o=1); grant in same cycle -> E2 WAIT; rvalid in cycle after E2 -> inst_valid_o=1 after E3.
- Peak throughput one instruction per 2 cycles (grant cycle + response cycle), with zero-wait memory.
- imem_req_o held with stable imem_addr_o until granted, unless flush_i changes pc_q (new address next cycle).
- All outputs registered except imem_req_o/imem_addr_o, which decode from state and pc_q only (no input-to-output combinational paths).
- Reset asserted mid-fetch: outstanding response after release is ignored (state IDLE/REQ does not sample rvalid).

## Test plan
- Reset release, gnt tied 1, rvalid one cycle after grant, rdata=0x00500093 -> first req at 0x0, inst_valid_o=1, pc_o=0x0, inst_o=0x00500093 after E3; next req addr 0x4.
- Stall 5 cycles with valid instruction at pc 0x4 and fetch of 0x8 in flight -> 0x8 lands in skid, state HOLD, no req; stall drop -> pc_o=0x8 next cycle, then req for 0xC.
- Flush with redirect_pc_i=0x103 while in WAIT -> pending response discarded, inst_valid_o=0, inst_o=0x00000013, next req addr 0x100.
- Flush same cycle as grant of 0x10, redirect 0x200 -> response for 0x10 never reaches inst_o; next req addr 0x200.
- Flush while stalled in HOLD -> skid and output cleared, inst_valid_o=0, req at redirect target next cycle.
- pc_q=0xFFFFFFFC granted -> next fetch address 0x00000000.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one-outstanding imem handshake, skid buffer and IF/ID output register
module if_stage #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              inst_valid_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, req_pc_d, skid_pc_q, skid_pc_d, pc_out_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d, inst_d;
  logic kill_q, kill_d, skid_full_q, skid_full_d, valid_d;
  assign imem_req_o  = state_q == REQ;
  assign imem_addr_o = pc_q;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_full_d = skid_full_q;
    inst_d      = inst_o;
    pc_out_d    = pc_o;
    valid_d     = inst_valid_o;
    if (inst_valid_o && !stall_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
    case (state_q)
      IDLE: state_d = REQ;
      REQ: if (imem_gnt_i) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + ADDR_W'(4);
        state_d  = WAIT;
      end
      WAIT: if (imem_rvalid_i) begin
        state_d = REQ;
        if (kill_q) kill_d = 1'b0;
        else if (!inst_valid_o || !stall_i) begin
          inst_d   = imem_rdata_i;
          pc_out_d = req_pc_q;
          valid_d  = 1'b1;
        end else begin
          skid_inst_d = imem_rdata_i;
          skid_pc_d   = req_pc_q;
          skid_full_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: if (!stall_i) begin
        inst_d      = skid_inst_q;
        pc_out_d    = skid_pc_q;
        valid_d     = 1'b1;
        skid_full_d = 1'b0;
        state_d     = REQ;
      end
      default: state_d = IDLE;
    endcase
    // A fetch already granted or still in flight on the old path must be swallowed when it returns
    if (flush_i && state_q != IDLE) begin
      pc_d        = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      valid_d     = 1'b0;
      inst_d      = NOP_INST;
      skid_full_d = 1'b0;
      if ((state_q == WAIT && !imem_rvalid_i) || (state_q == REQ && imem_gnt_i)) begin
        state_d = WAIT;
        kill_d  = 1'b1;
      end else state_d = REQ;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      skid_inst_q  <= NOP_INST;
      skid_pc_q    <= '0;
      skid_full_q  <= 1'b0;
      inst_o       <= NOP_INST;
      pc_o         <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      skid_full_q  <= skid_full_d;
      inst_o       <= inst_d;
      pc_o         <= pc_out_d;
      inst_valid_o <= valid_d;
    end
  end
endmodule
